// File: rtl/encoder_position_ctrl.sv
// Turns a wrapping quadrature count into a signed absolute position, homes on the
// encoder index pulse, and emits periodic position/velocity samples over valid/ready.
module encoder_position_ctrl #(
  parameter int CNT_W   = 8,
  parameter int POS_W   = 32,
  parameter int PERIOD  = 1000,
  parameter int TIMEOUT = 100000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             index_i,
  input  logic             home_req_i,
  output logic [POS_W-1:0] position_o,
  output logic [POS_W-1:0] velocity_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [POS_W-1:0] position_s_o,
  output logic             homed_o,
  output logic             fault_o,
  output logic             overrun_o
);

  localparam int PER_W = $clog2(PERIOD);
  localparam int TO_W  = $clog2(TIMEOUT);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_SEEK, S_ZERO, S_TRACK, S_FAULT} state_e;

  state_e           state_q, state_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [CNT_W-1:0] prev_q;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] base_q, base_d;
  logic [POS_W-1:0] vel_q, vel_d;
  logic [POS_W-1:0] ps_q, ps_d;
  logic [PER_W-1:0] per_q, per_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;
  logic             sync1_q, sync2_q, last_q;

  logic [CNT_W-1:0] delta;
  logic [POS_W-1:0] delta_ext;
  logic             idx_rise;
  logic             samp;

  // Decoder moves at most one step per clock, so the modular difference read as
  // signed recovers the direction across the count wrap.
  assign delta     = count_i - prev_q;
  assign delta_ext = {{(POS_W-CNT_W){delta[CNT_W-1]}}, delta};
  assign idx_rise  = sync2_q & ~last_q;
  assign samp      = (per_q == PER_LAST);

  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE, S_TRACK, S_FAULT: begin
        if (home_req_i) begin
          state_d = S_SEEK;
          to_d    = '0;
        end
      end
      S_SEEK: begin
        if (idx_rise)             state_d = S_ZERO;
        else if (to_q == TO_LAST) state_d = S_FAULT;
        else                      to_d    = to_q + TO_W'(1);
      end
      S_ZERO:  state_d = S_TRACK;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pos_d  = (state_q == S_ZERO) ? delta_ext : pos_q + delta_ext;
    per_d  = samp ? '0 : per_q + PER_W'(1);
    base_d = base_q;
    vel_d  = vel_q;
    ps_d   = ps_q;
    vld_d  = vld_q;
    ovr_d  = ovr_q;
    if (vld_q && out_ready_i) vld_d = 1'b0;
    if (samp) begin
      base_d = pos_q;
      if (!vld_q || out_ready_i) begin
        vld_d = 1'b1;
        vel_d = pos_q - base_q;
        ps_d  = pos_q;
      end else begin
        ovr_d = 1'b1;
      end
    end
    // Homing restarts the velocity reference so the pre-home offset never leaks in.
    if (state_q == S_ZERO) base_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      to_q    <= '0;
      prev_q  <= count_i;
      pos_q   <= '0;
      base_q  <= '0;
      vel_q   <= '0;
      ps_q    <= '0;
      per_q   <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      prev_q  <= count_i;
      pos_q   <= pos_d;
      base_q  <= base_d;
      vel_q   <= vel_d;
      ps_q    <= ps_d;
      per_q   <= per_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
      sync1_q <= index_i;
      sync2_q <= sync1_q;
      last_q  <= sync2_q;
    end
  end

  assign position_o   = pos_q;
  assign velocity_o   = vel_q;
  assign position_s_o = ps_q;
  assign out_valid_o  = vld_q;
  assign overrun_o    = ovr_q;
  assign homed_o      = (state_q == S_TRACK);
  assign fault_o      = (state_q == S_FAULT);

endmodule
